// File: rtl/nv_nvdla_pdp_pool1d_engine.sv
// Horizontal pooling engine: pads each line, runs overlapping SUM/MAX/MIN
// windows (K<=KMAX, any stride) and emits one widened result per window.
// Ports: nvdla_core_clk/rstn, op_en + cfg_* (latched at start),
//   in_valid/in_ready/in_pd (TP x DW pixel), out_valid/out_ready/out_pd
//   (TP x OW result), out_last (last window of line), busy, done.
`timescale 1ns/1ps
module nv_nvdla_pdp_pool1d_engine #(
  parameter int TP   = 8,
  parameter int DW   = 16,
  parameter int KMAX = 8,
  parameter int WW   = 13,
  parameter int OW   = DW + $clog2(KMAX)
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   op_en,
  input  logic [WW-1:0]          cfg_width,
  input  logic [WW-1:0]          cfg_lines,
  input  logic [$clog2(KMAX)-1:0] cfg_kernel,
  input  logic [3:0]             cfg_stride,
  input  logic [2:0]             cfg_pad_l,
  input  logic [2:0]             cfg_pad_r,
  input  logic [OW-1:0]          cfg_pad_value,
  input  logic [1:0]             cfg_type,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TP*DW-1:0]       in_pd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TP*OW-1:0]       out_pd,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int KW = $clog2(KMAX);
  localparam int XW = WW + 3;

  typedef enum logic [1:0] {IDLE, PAD_L, DATA, PAD_R} st_t;

  st_t st_q, st_d;

  logic [WW-1:0]    width_q, width_d;
  logic [WW-1:0]    lines_q, lines_d;
  logic [KW-1:0]    kern_q, kern_d;
  logic [3:0]       strd_q, strd_d;
  logic [2:0]       padl_q, padl_d;
  logic [2:0]       padr_q, padr_d;
  logic [OW-1:0]    padv_q, padv_d;
  logic [1:0]       type_q, type_d;

  logic [WW-1:0]    cnt_q, cnt_d;
  logic [WW-1:0]    line_q, line_d;
  logic [XW-1:0]    x_q, x_d;
  logic [XW-1:0]    nxt_q, nxt_d;
  logic [KW-1:0]    wslot_q, wslot_d;
  logic             fin_q, fin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [KMAX-1:0]  open_q, open_d;
  logic [KMAX-1:0]  has_q, has_d;
  logic [KMAX-1:0]  last_q, last_d;
  logic [XW-1:0]    end_q [KMAX];
  logic [XW-1:0]    end_d [KMAX];
  logic [TP*OW-1:0] acc_q [KMAX];
  logic [TP*OW-1:0] acc_d [KMAX];

  logic             ov_q, ov_d;
  logic [TP*OW-1:0] opd_q, opd_d;
  logic             olast_q, olast_d;

  logic             adv, step, pad_el;
  logic             is_max, is_min, is_sum;
  logic             opening, last_new, line_end;
  logic [XW-1:0]    pend, win_end;
  logic [DW-1:0]    din_v;
  logic signed [OW-1:0] el_v, ac_v;

  assign is_max = (type_q == 2'd1);
  assign is_min = (type_q == 2'd2);
  assign is_sum = !is_max && !is_min;

  // A step is blocked while an unaccepted result is held, so nothing
  // downstream of the slots ever needs buffering.
  assign adv    = !ov_q || out_ready;
  assign pad_el = (st_q != DATA);
  assign step   = adv && !fin_q &&
                  ((st_q == PAD_L) || (st_q == PAD_R) ||
                   ((st_q == DATA) && in_valid));
  assign in_ready = (st_q == DATA) && adv && !fin_q;

  // Last padded position of the line and end of a window opened here.
  assign pend    = XW'(padl_q) + XW'(width_q) + XW'(padr_q);
  assign win_end = x_q + XW'(kern_q);
  assign opening = step && (x_q == nxt_q) && (win_end <= pend);
  // Final window: the following start would no longer fit the line.
  assign last_new = (win_end + XW'(strd_q) + XW'(1)) > pend;

  always_comb begin
    ov_d    = ov_q && !out_ready;
    opd_d   = opd_q;
    olast_d = olast_q;
    din_v   = '0;
    el_v    = '0;
    ac_v    = '0;
    for (int s = 0; s < KMAX; s++) begin
      open_d[s] = open_q[s];
      has_d[s]  = has_q[s];
      last_d[s] = last_q[s];
      end_d[s]  = end_q[s];
      acc_d[s]  = acc_q[s];
      if (opening && (KW'(s) == wslot_q)) begin
        open_d[s] = 1'b1;
        has_d[s]  = 1'b0;
        last_d[s] = last_new;
        end_d[s]  = win_end;
        acc_d[s]  = '0;
      end
      if (step && open_d[s]) begin
        for (int l = 0; l < TP; l++) begin
          din_v = in_pd[l*DW +: DW];
          el_v  = pad_el ? $signed(padv_q)
                         : $signed({{(OW-DW){din_v[DW-1]}}, din_v});
          ac_v  = $signed(acc_d[s][l*OW +: OW]);
          if (is_sum) begin
            ac_v = ac_v + el_v;
          end else if (!pad_el) begin
            if (!has_d[s]) ac_v = el_v;
            else if (is_max && (el_v > ac_v)) ac_v = el_v;
            else if (is_min && (el_v < ac_v)) ac_v = el_v;
          end
          acc_d[s][l*OW +: OW] = ac_v;
        end
        if (!pad_el) has_d[s] = 1'b1;
        if (end_d[s] == x_q) begin
          open_d[s] = 1'b0;
          ov_d      = 1'b1;
          olast_d   = last_d[s];
          // A MAX/MIN window that saw only padding reports the pad value.
          opd_d     = (is_sum || has_d[s]) ? acc_d[s] : {TP{padv_q}};
        end
      end
    end
  end

  always_comb begin
    st_d    = st_q;
    width_d = width_q;
    lines_d = lines_q;
    kern_d  = kern_q;
    strd_d  = strd_q;
    padl_d  = padl_q;
    padr_d  = padr_q;
    padv_d  = padv_q;
    type_d  = type_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    x_d     = x_q;
    nxt_d   = nxt_q;
    wslot_d = wslot_q;
    fin_d   = fin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    line_end = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (op_en) begin
          width_d = cfg_width;
          lines_d = cfg_lines;
          kern_d  = cfg_kernel;
          strd_d  = cfg_stride;
          padl_d  = cfg_pad_l;
          padr_d  = cfg_pad_r;
          padv_d  = cfg_pad_value;
          type_d  = cfg_type;
          busy_d  = 1'b1;
          cnt_d   = '0;
          line_d  = '0;
          x_d     = '0;
          nxt_d   = '0;
          wslot_d = '0;
          st_d    = (cfg_pad_l != 3'd0) ? PAD_L : DATA;
        end
      end
      PAD_L: begin
        if (step) begin
          if (cnt_q + WW'(1) == WW'(padl_q)) begin
            cnt_d = '0;
            st_d  = DATA;
          end else begin
            cnt_d = cnt_q + WW'(1);
          end
        end
      end
      DATA: begin
        if (step) begin
          if (cnt_q == width_q) begin
            cnt_d = '0;
            if (padr_q != 3'd0) st_d = PAD_R;
            else line_end = 1'b1;
          end else begin
            cnt_d = cnt_q + WW'(1);
          end
        end
      end
      PAD_R: begin
        if (step) begin
          if (cnt_q + WW'(1) == WW'(padr_q)) line_end = 1'b1;
          else cnt_d = cnt_q + WW'(1);
        end
      end
    endcase
    if (step) begin
      x_d = x_q + XW'(1);
      if (x_q == nxt_q) nxt_d = nxt_q + XW'(strd_q) + XW'(1);
      if (opening)
        wslot_d = (wslot_q == KW'(KMAX-1)) ? '0 : wslot_q + KW'(1);
    end
    if (line_end) begin
      cnt_d   = '0;
      x_d     = '0;
      nxt_d   = '0;
      wslot_d = '0;
      if (line_q == lines_q) begin
        fin_d = 1'b1;
      end else begin
        line_d = line_q + WW'(1);
        st_d   = (padl_q != 3'd0) ? PAD_L : DATA;
      end
    end
    // Finish only once the last result has left the output register.
    if (fin_q && adv) begin
      fin_d  = 1'b0;
      busy_d = 1'b0;
      done_d = 1'b1;
      st_d   = IDLE;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      st_q    <= IDLE;
      width_q <= '0;
      lines_q <= '0;
      kern_q  <= '0;
      strd_q  <= '0;
      padl_q  <= '0;
      padr_q  <= '0;
      padv_q  <= '0;
      type_q  <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
      x_q     <= '0;
      nxt_q   <= '0;
      wslot_q <= '0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      open_q  <= '0;
      has_q   <= '0;
      last_q  <= '0;
      for (int s = 0; s < KMAX; s++) begin
        end_q[s] <= '0;
        acc_q[s] <= '0;
      end
      ov_q    <= 1'b0;
      opd_q   <= '0;
      olast_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      width_q <= width_d;
      lines_q <= lines_d;
      kern_q  <= kern_d;
      strd_q  <= strd_d;
      padl_q  <= padl_d;
      padr_q  <= padr_d;
      padv_q  <= padv_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      x_q     <= x_d;
      nxt_q   <= nxt_d;
      wslot_q <= wslot_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      open_q  <= open_d;
      has_q   <= has_d;
      last_q  <= last_d;
      for (int s = 0; s < KMAX; s++) begin
        end_q[s] <= end_d[s];
        acc_q[s] <= acc_d[s];
      end
      ov_q    <= ov_d;
      opd_q   <= opd_d;
      olast_q <= olast_d;
    end
  end

  assign out_valid = ov_q;
  assign out_pd    = opd_q;
  assign out_last  = olast_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_nv_nvdla_pdp_pool1d_engine.sv
// Directed bench for the 1D pooling engine: SUM/MAX/MIN windows, padding,
// back-pressure, multi-line runs, empty lines and reset mid-operation.
`timescale 1ns/1ps
module tb_nv_nvdla_pdp_pool1d_engine;

  localparam int TP   = 8;
  localparam int DW   = 16;
  localparam int KMAX = 8;
  localparam int WW   = 13;
  localparam int OW   = DW + $clog2(KMAX);
  localparam int KW   = $clog2(KMAX);
  localparam int PW   = TP * OW;

  typedef logic [PW-1:0] pw_t;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            op_en = 1'b0;
  logic [WW-1:0]   cfg_width = '0;
  logic [WW-1:0]   cfg_lines = '0;
  logic [KW-1:0]   cfg_kernel = '0;
  logic [3:0]      cfg_stride = '0;
  logic [2:0]      cfg_pad_l = '0;
  logic [2:0]      cfg_pad_r = '0;
  logic [OW-1:0]   cfg_pad_value = '0;
  logic [1:0]      cfg_type = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [TP*DW-1:0] in_pd = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [PW-1:0]   out_pd;
  logic            out_last;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;

  logic [TP*DW-1:0] pix [64];
  pw_t              exp_pd [16];
  bit               exp_last [16];

  nv_nvdla_pdp_pool1d_engine #(
    .TP(TP), .DW(DW), .KMAX(KMAX), .WW(WW)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .op_en          (op_en),
    .cfg_width      (cfg_width),
    .cfg_lines      (cfg_lines),
    .cfg_kernel     (cfg_kernel),
    .cfg_stride     (cfg_stride),
    .cfg_pad_l      (cfg_pad_l),
    .cfg_pad_r      (cfg_pad_r),
    .cfg_pad_value  (cfg_pad_value),
    .cfg_type       (cfg_type),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pd          (in_pd),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pd         (out_pd),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input pw_t obs, input pw_t expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic pw_t ov(input int l0, input int rest);
    pw_t r;
    for (int l = 0; l < TP; l++)
      r[l*OW +: OW] = (l == 0) ? OW'(l0) : OW'(rest);
    return r;
  endfunction

  function automatic logic [TP*DW-1:0] iv(input int l0);
    logic [TP*DW-1:0] r;
    r = '0;
    r[DW-1:0] = DW'(l0);
    return r;
  endfunction

  task automatic start(input int w, input int ln, input int k, input int s,
                       input int pl, input int pr, input int pv,
                       input int ty);
    cfg_width     = WW'(w);
    cfg_lines     = WW'(ln);
    cfg_kernel    = KW'(k);
    cfg_stride    = 4'(s);
    cfg_pad_l     = 3'(pl);
    cfg_pad_r     = 3'(pr);
    cfg_pad_value = OW'(pv);
    cfg_type      = 2'(ty);
    op_en = 1'b1;
    @(posedge clk); #1;
    op_en = 1'b0;
    cfg_width = '0;
    cfg_kernel = '0;
    cfg_type = 2'd3;
  endtask

  task automatic run(input string tag, input int npix, input int nexp,
                     input bit gaps, input int stall_at,
                     input int abort_pix);
    int pi = 0;
    int oi = 0;
    int dn = 0;
    int stall = 0;
    int cyc = 0;
    bit stalled = 0;
    bit fin = 0;
    while (!fin && cyc < 3000) begin
      if (!stalled && stall_at == oi && out_valid) begin
        stall = 5;
        stalled = 1;
      end
      out_ready = (stall == 0);
      if (stall > 0) stall--;
      in_valid = (pi < npix) && (!gaps || $urandom_range(0, 2) != 0);
      in_pd = (pi < npix) ? pix[pi] : '0;
      @(negedge clk);
      if (!out_ready && out_valid) begin
        check({tag, " stall_pd"}, out_pd, exp_pd[oi]);
        check({tag, " stall_in_ready"}, pw_t'(in_ready), pw_t'(0));
      end
      if (out_valid && out_ready) begin
        if (oi < nexp) begin
          check({tag, " pd"}, out_pd, exp_pd[oi]);
          check({tag, " last"}, pw_t'(out_last), pw_t'(exp_last[oi]));
        end else begin
          check({tag, " extra_out"}, pw_t'(oi), pw_t'(nexp));
        end
        oi++;
      end
      if (in_valid && in_ready) pi++;
      if (done) begin
        dn++;
        fin = 1;
        check({tag, " busy_at_done"}, pw_t'(busy), pw_t'(0));
      end
      if (abort_pix > 0 && pi >= abort_pix) fin = 1;
      cyc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (abort_pix == 0) begin
      check({tag, " out_count"}, pw_t'(oi), pw_t'(nexp));
      check({tag, " pix_count"}, pw_t'(pi), pw_t'(npix));
      check({tag, " done_count"}, pw_t'(dn), pw_t'(1));
      check({tag, " done_pulse"}, pw_t'(done), pw_t'(0));
    end
  endtask

  task automatic load_min3();
    int v [10] = '{-4, 3, 2, 8, 1, 4, 0, 6, 9, -9};
    int m [3]  = '{-4, 0, -9};
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 10; p++)
        for (int l = 0; l < TP; l++)
          pix[k*10+p][l*DW +: DW] = DW'((l+1)*v[p] + 100*l + 1000*k);
      for (int j = 0; j < 3; j++) begin
        for (int l = 0; l < TP; l++)
          exp_pd[k*3+j][l*OW +: OW] = OW'((l+1)*m[j] + 100*l + 1000*k);
        exp_last[k*3+j] = (j == 2);
      end
    end
  endtask

  task automatic load_sum_k2s2();
    for (int p = 0; p < 4; p++) pix[p] = iv(p + 1);
    exp_pd[0] = ov(3, 0);  exp_last[0] = 0;
    exp_pd[1] = ov(7, 0);  exp_last[1] = 1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " in_ready"},  pw_t'(in_ready),  pw_t'(0));
    check({tag, " out_valid"}, pw_t'(out_valid), pw_t'(0));
    check({tag, " out_pd"},    out_pd,           pw_t'(0));
    check({tag, " out_last"},  pw_t'(out_last),  pw_t'(0));
    check({tag, " busy"},      pw_t'(busy),      pw_t'(0));
    check({tag, " done"},      pw_t'(done),      pw_t'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    load_sum_k2s2();
    start(3, 0, 1, 1, 0, 0, 0, 0);
    run("sum_k2s2", 4, 2, 0, -1, 0);

    pix[0] = iv(-5); pix[1] = iv(7); pix[2] = iv(2);
    for (int j = 0; j < 3; j++) begin
      exp_pd[j] = ov(7, 0);
      exp_last[j] = (j == 2);
    end
    start(2, 0, 2, 0, 1, 1, 100, 1);
    run("max_pad", 3, 3, 0, -1, 0);

    exp_pd[0] = ov(1, -1);
    exp_pd[1] = ov(4, 0);
    exp_pd[2] = ov(8, -1);
    start(2, 0, 2, 0, 1, 1, -1, 0);
    run("sum_pad_stall", 3, 3, 0, 1, 0);

    for (int p = 0; p < 6; p++) pix[p] = iv(p + 1);
    exp_pd[0] = ov(3, 0);  exp_last[0] = 0;
    exp_pd[1] = ov(9, 0);  exp_last[1] = 1;
    start(5, 0, 1, 2, 0, 0, 0, 0);
    run("sum_k2s3_tail", 6, 2, 0, -1, 0);

    for (int p = 0; p < 4; p++) pix[p] = iv(p + 1);
    start(3, 0, 7, 0, 0, 0, 0, 0);
    run("short_line", 4, 0, 0, -1, 0);

    load_min3();
    start(9, 2, 7, 0, 0, 0, 0, 2);
    run("min_3line", 30, 9, 1, -1, 0);

    start(9, 2, 7, 0, 0, 0, 0, 2);
    run("abort", 30, 9, 1, -1, 13);
    rstn = 1'b0;
    @(negedge clk);
    check_reset("mid_reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    load_sum_k2s2();
    start(3, 0, 1, 1, 0, 0, 0, 0);
    run("after_reset", 4, 2, 0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
